// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter
// Purpose  : Shares one single-port memory bus between the CPU's instruction
//            fetch port (I) and data port (D). Requests are serialised with
//            round-robin arbitration when both ports ask at once. The address,
//            store data and byte enables are latched onto the bus. The read
//            data and a one-cycle ack go back to the requesting port. An
//            access that gets no m_ack within TIMEOUT cycles is aborted,
//            returns all-ones data and pulses err.
// Ports    : clk, reset (async, active-low)
//            i_req/i_addr -> i_rdata/i_ack          fetch port
//            d_req/d_we/d_addr/d_wdata/d_be
//                         -> d_rdata/d_ack          data port
//            m_req/m_we/m_addr/m_wdata/m_be,
//            m_rdata/m_ack                          memory bus
//            busy, err                              status
// Revision : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_ack,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ack,
  output logic                m_req,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_be,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_ack,
  output logic                busy,
  output logic                err
);

  localparam int                BE_W     = DATA_W / 8;
  localparam int                CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
  // Fetches are always word aligned on the bus.
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS_I = 2'd1,
    BUS_D = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t            state_q;
  logic              last_grant_q;  // 0 = I was granted last, 1 = D
  logic [CNT_W-1:0]  cnt_q;
  logic              m_req_q;
  logic              m_we_q;
  logic [ADDR_W-1:0] m_addr_q;
  logic [DATA_W-1:0] m_wdata_q;
  logic [BE_W-1:0]   m_be_q;
  logic              i_ack_q;
  logic              d_ack_q;
  logic [DATA_W-1:0] i_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              err_q;
  logic              grant_d;       // port that wins if a grant happens now

  // D wins when it is the only requester, or when both ask and I had the
  // previous grant. Reset leaves last_grant at I, so D takes the first tie.
  always_comb begin
    grant_d = d_req & (~i_req | ~last_grant_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b0;
      cnt_q        <= '0;
      m_req_q      <= 1'b0;
      m_we_q       <= 1'b0;
      m_addr_q     <= '0;
      m_wdata_q    <= '0;
      m_be_q       <= '0;
      i_ack_q      <= 1'b0;
      d_ack_q      <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      // Acks and err are single-cycle pulses unless set below.
      i_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_req || d_req) begin
            state_q      <= grant_d ? BUS_D : BUS_I;
            last_grant_q <= grant_d;
            cnt_q        <= '0;
            m_req_q      <= 1'b1;
            if (grant_d) begin
              m_we_q    <= d_we;
              m_addr_q  <= d_addr;
              m_wdata_q <= d_wdata;
              m_be_q    <= d_be;
            end else begin
              m_we_q    <= 1'b0;
              m_addr_q  <= i_addr & WORD_MASK;
              m_wdata_q <= '0;
              m_be_q    <= '1;
            end
          end
        end
        BUS_I, BUS_D: begin
          // m_ack is checked first so a reply on the last allowed cycle
          // still completes normally.
          if (m_ack) begin
            m_req_q <= 1'b0;
            state_q <= RESP;
            if (state_q == BUS_D) begin
              d_rdata_q <= m_rdata;
              d_ack_q   <= 1'b1;
            end else begin
              i_rdata_q <= m_rdata;
              i_ack_q   <= 1'b1;
            end
          end else if (cnt_q == CNT_LAST) begin
            m_req_q <= 1'b0;
            err_q   <= 1'b1;
            state_q <= RESP;
            if (state_q == BUS_D) begin
              d_rdata_q <= '1;
              d_ack_q   <= 1'b1;
            end else begin
              i_rdata_q <= '1;
              i_ack_q   <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP: begin
          // Requests are deliberately ignored here so the requester can
          // drop req in the ack cycle without launching a second access.
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_req   = m_req_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign m_be    = m_be_q;
  assign i_ack   = i_ack_q;
  assign d_ack   = d_ack_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign err     = err_q;
  assign busy    = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_bus_arbiter
// Purpose  : Self-checking bench for mem_bus_arbiter. A memory responder
//            returns addr ^ 0x2001_0001 after a programmable wait. Expected
//            port responses are queued when a request is raised and are
//            compared when the matching ack appears.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_be;
  logic [31:0] m_rdata;
  logic        m_ack;
  logic        busy;
  logic        err;

  int   n_tests;
  int   n_fail;
  exp_t iq[$];
  exp_t dq[$];
  bit   glog[$];          // ack order: 1 = D, 0 = I
  int   mem_wait;
  bit   mem_mute;
  int   last_req_len;
  int   req_len;
  int   d_ack_cnt;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(64)) dut (
    .clk     (clk),
    .reset   (reset),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_rdata (i_rdata),
    .i_ack   (i_ack),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_be    (d_be),
    .d_rdata (d_rdata),
    .d_ack   (d_ack),
    .m_req   (m_req),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_be    (m_be),
    .m_rdata (m_rdata),
    .m_ack   (m_ack),
    .busy    (busy),
    .err     (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] a);
    return a ^ 32'h2001_0001;
  endfunction

  // Memory responder: acks after mem_wait idle cycles of m_req.
  initial begin
    int wcnt;
    wcnt    = 0;
    m_ack   = 1'b0;
    m_rdata = '0;
    forever begin
      @(negedge clk);
      if (m_req && !mem_mute) begin
        if (wcnt == mem_wait) begin
          m_ack   = 1'b1;
          m_rdata = model(m_addr);
          wcnt    = 0;
        end else begin
          m_ack   = 1'b0;
          m_rdata = $urandom;
          wcnt++;
        end
      end else begin
        m_ack   = 1'b0;
        m_rdata = $urandom;
        wcnt    = 0;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    logic         m_req_prev;
    logic         i_ack_prev;
    logic         d_ack_prev;
    logic [127:0] cap;
    exp_t         e;
    m_req_prev = 1'b0;
    i_ack_prev = 1'b0;
    d_ack_prev = 1'b0;
    cap        = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (m_req && m_req_prev) begin
          chk("m_stable", {m_we, m_addr, m_wdata, m_be}, cap);
          req_len++;
        end else if (m_req) begin
          cap     = {m_we, m_addr, m_wdata, m_be};
          req_len = 1;
        end
        if (!m_req && m_req_prev) last_req_len = req_len;
        if (i_ack) begin
          chk("i_ack_pulse", i_ack_prev, 0);
          chk("ack_exclusive", d_ack, 0);
          chk("i_ack_expected", iq.size() != 0, 1);
          if (iq.size() != 0) begin
            e = iq.pop_front();
            chk("i_rdata", i_rdata, e.rdata);
            chk("i_err", err, e.err);
          end
          glog.push_back(1'b0);
        end
        if (d_ack) begin
          d_ack_cnt++;
          chk("d_ack_pulse", d_ack_prev, 0);
          chk("d_ack_expected", dq.size() != 0, 1);
          if (dq.size() != 0) begin
            e = dq.pop_front();
            chk("d_rdata", d_rdata, e.rdata);
            chk("d_err", err, e.err);
          end
          glog.push_back(1'b1);
        end
        if (err) chk("err_with_ack", i_ack | d_ack, 1);
      end
      m_req_prev = m_req;
      i_ack_prev = i_ack;
      d_ack_prev = d_ack;
    end
  end

  // One complete access on one port; returns negedges from request to ack
  // and the number of those negedges on which busy was high.
  task automatic access(input bit is_d, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input int wait_n, input bit mute,
                        output int lat, output int busy_n);
    exp_t        e;
    logic [31:0] baddr;
    bit          got;
    baddr    = is_d ? addr : {addr[31:2], 2'b00};
    e.err    = mute;
    e.rdata  = mute ? 32'hFFFF_FFFF : model(baddr);
    mem_wait = wait_n;
    mem_mute = mute;
    @(negedge clk);
    if (is_d) begin
      dq.push_back(e);
      d_we = we; d_addr = addr; d_wdata = wdata; d_be = be; d_req = 1'b1;
    end else begin
      iq.push_back(e);
      i_addr = addr; i_req = 1'b1;
    end
    lat = 0; busy_n = 0; got = 1'b0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      lat++;
      if (busy) busy_n++;
      if (lat == 1) begin
        chk("m_req_up", m_req, 1);
        chk("m_addr", m_addr, baddr);
        chk("m_we", m_we, is_d & we);
        chk("m_be", m_be, is_d ? be : 4'hF);
        if (is_d) chk("m_wdata", m_wdata, wdata);
      end
      if (is_d ? d_ack : i_ack) begin
        got = 1'b1;
        if (is_d) d_req = 1'b0; else i_req = 1'b0;
      end
    end
    chk("ack_seen", got, 1);
    @(negedge clk);
    mem_mute = 1'b0;
  endtask

  task automatic requester(input bit is_d, input int n);
    logic [31:0] a;
    exp_t        e;
    bit          got;
    for (int k = 0; k < n; k++) begin
      got = 1'b0;
      a   = is_d ? (32'h0000_0100 + 32'(k * 4)) : (32'h0000_0202 + 32'(k * 4));
      e.err   = 1'b0;
      e.rdata = model(is_d ? a : {a[31:2], 2'b00});
      if (is_d) begin
        dq.push_back(e);
        d_we = 1'b0; d_addr = a; d_be = 4'hF; d_req = 1'b1;
      end else begin
        iq.push_back(e);
        i_addr = a; i_req = 1'b1;
      end
      for (int c = 0; c < 50 && !got; c++) begin
        @(negedge clk);
        if (is_d ? d_ack : i_ack) begin
          got = 1'b1;
          if (is_d) d_req = 1'b0; else i_req = 1'b0;
        end
      end
      chk(is_d ? "rr_d_ack_seen" : "rr_i_ack_seen", got, 1);
      @(negedge clk);
    end
  endtask

  initial begin
    int lat;
    int busy_n;
    int saved;
    bit got;
    n_tests = 0; n_fail = 0;
    mem_wait = 0; mem_mute = 1'b0;
    last_req_len = 0; req_len = 0; d_ack_cnt = 0;
    reset = 1'b0;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_bus", {m_req, m_we, m_addr, m_wdata, m_be}, 0);
    chk("rst_port", {i_ack, d_ack, i_rdata, d_rdata, busy, err}, 0);
    reset = 1'b1;

    // Reset in the middle of a store: everything clears without a clock,
    // and no ack ever follows.
    mem_mute = 1'b1;
    @(negedge clk);
    d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'h1234_5678; d_be = 4'hF; d_req = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 5 && !got; c++) begin
      @(negedge clk);
      if (m_req) got = 1'b1;
    end
    chk("mid_m_req_up", got, 1);
    chk("mid_busy", busy, 1);
    saved = d_ack_cnt;
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_bus", {m_req, m_we, m_addr, m_wdata, m_be}, 0);
    chk("mid_rst_port", {i_ack, d_ack, i_rdata, d_rdata, busy, err}, 0);
    d_req = 1'b0; d_we = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    mem_mute = 1'b0;
    repeat (6) @(negedge clk);
    chk("mid_no_dack", d_ack_cnt, saved);
    chk("mid_idle", busy, 0);

    // Unaligned fetch, single-cycle memory.
    access(1'b0, 1'b0, 32'h0000_0007, 32'h0, 4'h0, 0, 1'b0, lat, busy_n);
    chk("fetch_lat", lat, 2);
    chk("fetch_busy", busy_n, 2);
    chk("fetch_reqlen", last_req_len, 1);

    // Partial store with three wait cycles.
    access(1'b1, 1'b1, 32'h0000_0010, 32'hCAFE_F00D, 4'b0011, 3, 1'b0, lat, busy_n);
    chk("store_lat", lat, 5);
    chk("store_reqlen", last_req_len, 4);

    // Load timeout.
    access(1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'hF, 0, 1'b1, lat, busy_n);
    chk("tmo_lat", lat, 65);
    chk("tmo_reqlen", last_req_len, 64);

    // m_ack on the last allowed cycle completes normally.
    access(1'b1, 1'b0, 32'h0000_0044, 32'h0, 4'hF, 63, 1'b0, lat, busy_n);
    chk("edge_lat", lat, 65);
    chk("edge_reqlen", last_req_len, 64);

    // Fetch timeout too.
    access(1'b0, 1'b0, 32'h0000_0081, 32'h0, 4'h0, 0, 1'b1, lat, busy_n);
    chk("itmo_lat", lat, 65);

    // Round-robin with both ports requesting from the first cycle after reset.
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    glog.delete();
    mem_wait = 0;
    reset = 1'b1;
    fork
      requester(1'b1, 3);
      requester(1'b0, 3);
    join
    repeat (2) @(negedge clk);
    chk("rr_count", glog.size(), 6);
    for (int k = 0; k < 6 && k < glog.size(); k++) begin
      chk("rr_order", glog[k], (k % 2) == 0);
    end

    chk("iq_drained", iq.size(), 0);
    chk("dq_drained", dq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
